fir_data_buf_ctrl: RTL and testbench



---
 rtl/fir_data_buf_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fir_data_buf_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_data_buf_ctrl.sv
// ---------------------------------------------------------------------------
// fir_data_buf_ctrl
//
// Circular-buffer controller for the FIR data BRAM. Each input sample is
// written at a rotating pointer. The TAPS most recent samples are then read
// back newest first and handed to the MAC stage over a valid/ready
// handshake, each tagged with its tap index.
//
// Optional build macro:
//   FIR_DATA_CLEAR_EN  - when defined, every accepted ap_start zero-fills all
//                        TAPS BRAM words (one per cycle) before the first
//                        sample is accepted. When undefined, the clear phase
//                        does not exist, so stale words from a previous run
//                        show up on taps that have not been overwritten yet.
//
// Ports:
//   CLK, RST          clock (rising edge) and synchronous active-high reset
//   ap_start          start pulse, honoured only while ap_idle=1
//   data_length       samples per run, latched on an accepted ap_start
//   ap_idle, ap_done  idle level / one-cycle completion pulse
//   ss_tvalid/tdata/tready   input sample stream
//   bram_WE/EN/Di/A/Do       data BRAM port (A is a byte address, word<<2;
//                            read data arrives one cycle after the address
//                            and is only valid while EN=1)
//   x_valid/ready/data/idx/last/final   tap sample stream to the MAC
// ---------------------------------------------------------------------------
module fir_data_buf_ctrl #(
  parameter int TAPS = 11,
  parameter int DW   = 32,
  parameter int AW   = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  output logic          ap_idle,
  output logic          ap_done,
  input  logic          ss_tvalid,
  input  logic [DW-1:0] ss_tdata,
  output logic          ss_tready,
  output logic [3:0]    bram_WE,
  output logic          bram_EN,
  output logic [DW-1:0] bram_Di,
  output logic [AW-1:0] bram_A,
  input  logic [DW-1:0] bram_Do,
  output logic          x_valid,
  input  logic          x_ready,
  output logic [DW-1:0] x_data,
  output logic [3:0]    x_idx,
  output logic          x_last,
  output logic          x_final
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    RD_ADDR,
    RD_DATA,
    OUT,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [KW-1:0]   r_ptr;      // word holding the newest sample
  logic [KW-1:0]   r_k;        // tap index; also the word counter while clearing
  logic [31:0]     r_len;
  logic [31:0]     r_cnt;      // samples fully delivered this run

  logic            r_x_valid;
  logic [DW-1:0]   r_x_data;
  logic [3:0]      r_x_idx;
  logic            r_x_last;
  logic            r_x_final;

  logic [KW-1:0]   w_rd_word;
  logic            w_k_last;
  logic            w_cnt_last;
  logic            w_run_empty;
  logic            w_ss_hs;
  logic            w_x_hs;
  logic [31:0]     w_cnt_inc;

  assign w_k_last    = (r_k == KW'(TAPS - 1));
  assign w_cnt_inc   = r_cnt + 32'd1;
  assign w_cnt_last  = (w_cnt_inc == r_len);
  // Only true in WAIT_IN for a zero-length run; a finished run leaves via OUT.
  assign w_run_empty = (r_cnt == r_len);
  assign w_ss_hs     = ss_tvalid && ss_tready;
  assign w_x_hs      = r_x_valid && x_ready;

  // Word (ptr - k) mod TAPS. When k exceeds ptr the sum ptr+TAPS-k is in
  // range even though ptr+TAPS may overflow KW bits mid-expression.
  always_comb begin
    if (r_ptr >= r_k) begin
      w_rd_word = r_ptr - r_k;
    end else begin
      w_rd_word = r_ptr + KW'(TAPS) - r_k;
    end
  end

  assign ap_idle   = (r_state == IDLE);
  assign ap_done   = (r_state == DONE);
  assign ss_tready = (r_state == WAIT_IN) && !w_run_empty;

  assign x_valid   = r_x_valid;
  assign x_data    = r_x_data;
  assign x_idx     = r_x_idx;
  assign x_last    = r_x_last;
  assign x_final   = r_x_final;

  // Next state and BRAM port drive.
  always_comb begin
    w_state_next = r_state;
    bram_WE      = 4'h0;
    bram_EN      = 1'b0;
    bram_Di      = '0;
    bram_A       = '0;

    case (r_state)
      IDLE: begin
        if (ap_start) begin
`ifdef FIR_DATA_CLEAR_EN
          w_state_next = CLEAR;
`else
          w_state_next = WAIT_IN;
`endif
        end
      end

`ifdef FIR_DATA_CLEAR_EN
      CLEAR: begin
        bram_EN = 1'b1;
        bram_WE = 4'hF;
        bram_A  = AW'({r_k, 2'b00});
        if (w_k_last) begin
          w_state_next = (r_len == 32'd0) ? DONE : WAIT_IN;
        end
      end
`endif

      WAIT_IN: begin
        if (w_run_empty) begin
          w_state_next = DONE;
        end else if (w_ss_hs) begin
          // Write commits on this edge, ahead of the first read address.
          bram_EN      = 1'b1;
          bram_WE      = 4'hF;
          bram_A       = AW'({r_ptr, 2'b00});
          bram_Di      = ss_tdata;
          w_state_next = RD_ADDR;
        end
      end

      RD_ADDR: begin
        bram_EN      = 1'b1;
        bram_A       = AW'({w_rd_word, 2'b00});
        w_state_next = RD_DATA;
      end

      RD_DATA: begin
        // EN stays high so the gated read data is visible this cycle.
        bram_EN      = 1'b1;
        bram_A       = AW'({w_rd_word, 2'b00});
        w_state_next = OUT;
      end

      OUT: begin
        if (x_ready) begin
          if (!w_k_last) begin
            w_state_next = RD_ADDR;
          end else if (w_cnt_last) begin
            w_state_next = DONE;
          end else begin
            w_state_next = WAIT_IN;
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointer, counters and output stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= '0;
      r_k       <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_x_valid <= 1'b0;
      r_x_data  <= '0;
      r_x_idx   <= '0;
      r_x_last  <= 1'b0;
      r_x_final <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_len <= data_length;
            r_ptr <= '0;
            r_cnt <= '0;
            r_k   <= '0;
          end
        end

        CLEAR: begin
          r_k <= w_k_last ? '0 : r_k + KW'(1);
        end

        WAIT_IN: begin
          if (w_ss_hs) begin
            r_k <= '0;
          end
        end

        RD_DATA: begin
          r_x_data  <= bram_Do;
          r_x_idx   <= 4'(r_k);
          r_x_last  <= w_k_last;
          r_x_final <= w_k_last && w_cnt_last;
          r_x_valid <= 1'b1;
        end

        OUT: begin
          if (w_x_hs) begin
            r_x_valid <= 1'b0;
            if (!w_k_last) begin
              r_k <= r_k + KW'(1);
            end else begin
              r_ptr <= (r_ptr == KW'(TAPS - 1)) ? '0 : r_ptr + KW'(1);
              r_cnt <= w_cnt_inc;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_data_buf_ctrl.sv
module tb_fir_data_buf_ctrl;

  localparam int TAPS = 11;
  localparam int DW   = 32;
  localparam int AW   = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ap_start = 1'b0;
  logic [31:0]   data_length = '0;
  logic          ap_idle;
  logic          ap_done;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tready;
  logic [3:0]    bram_WE;
  logic          bram_EN;
  logic [DW-1:0] bram_Di;
  logic [AW-1:0] bram_A;
  logic [DW-1:0] bram_Do;
  logic          x_valid;
  logic          x_ready = 1'b1;
  logic [DW-1:0] x_data;
  logic [3:0]    x_idx;
  logic          x_last;
  logic          x_final;

  fir_data_buf_ctrl #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .bram_WE(bram_WE), .bram_EN(bram_EN), .bram_Di(bram_Di),
    .bram_A(bram_A), .bram_Do(bram_Do),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .x_idx(x_idx), .x_last(x_last), .x_final(x_final)
  );

  always #5 CLK = ~CLK;

  // BRAM model: byte-enable write, registered read address, EN-gated data.
  logic [DW-1:0] mem [TAPS];
  logic [3:0]    rd_word = '0;
  initial for (int i = 0; i < TAPS; i++) mem[i] = '0;
  always @(posedge CLK) begin
    if (bram_EN) begin
      for (int b = 0; b < 4; b++)
        if (bram_WE[b]) mem[bram_A[5:2]][8*b +: 8] <= bram_Di[8*b +: 8];
      rd_word <= bram_A[5:2];
    end
  end
  assign bram_Do = bram_EN ? mem[rd_word] : '0;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        fin;
  } tap_t;

  tap_t sb[$];          // expected tap outputs, in order
  tap_t vec[TAPS];      // expected taps of the captured sample
  tap_t cap[TAPS];      // observed taps of the captured sample
  logic cap_en = 1'b0;

  // Reference circular buffer
  logic [31:0] ref_mem [TAPS];
  int m_ptr = 0, m_cnt = 0, m_len = 0;

  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_wr = 0, n_trdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(negedge CLK);
    #2;
  endtask

  // Monitor: scoreboard pops on each tap handshake, plus event counters.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ap_done) n_done++;
      if (bram_EN && bram_WE != 4'h0) n_wr++;
      if (ss_tready) n_trdy++;
      if (x_valid && x_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL x_unexpected: got tap idx %0d data %0h expected none", x_idx, x_data);
        end else begin
          tap_t e;
          e = sb.pop_front();
          $display("tap idx=%0d data=%0h last=%0b final=%0b", x_idx, x_data, x_last, x_final);
          chk("x_idx", 32'(x_idx), 32'(e.idx));
          chk("x_data", x_data, e.data);
          chk("x_last", 32'(x_last), 32'(e.last));
          chk("x_final", 32'(x_final), 32'(e.fin));
        end
        if (cap_en && x_idx < 4'(TAPS)) begin
          cap[x_idx].idx  = x_idx;
          cap[x_idx].data = x_data;
          cap[x_idx].last = x_last;
          cap[x_idx].fin  = x_final;
        end
      end
    end
  end

  task automatic start(input int len);
    @(posedge CLK); #1;
    ap_start = 1'b1;
    data_length = 32'(len);
    m_len = len; m_cnt = 0; m_ptr = 0;
`ifdef FIR_DATA_CLEAR_EN
    for (int i = 0; i < TAPS; i++) ref_mem[i] = '0;
`endif
    @(posedge CLK); #1;
    ap_start = 1'b0;
`ifdef FIR_DATA_CLEAR_EN
    for (int i = 0; i < TAPS; i++) begin
      tick;
      chk("clr_we", 32'(bram_WE), 32'hF);
      chk("clr_en", 32'(bram_EN), 1);
      chk("clr_di", bram_Di, 0);
      chk("clr_a", 32'(bram_A), 32'(i * 4));
    end
`endif
    tick;
    chk("start_busy", 32'(ap_idle), 0);
    chk("start_tready", 32'(ss_tready), 1);
  endtask

  task automatic stall_seq;
    int c;
    @(posedge CLK); #1;
    x_ready = 1'b0;
    c = 0;
    do begin tick; c++; end while (!x_valid && c < 10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(x_valid), 1);
      chk("stall_idx", 32'(x_idx), 3);
      chk("stall_data", x_data, sb[0].data);
      chk("stall_en", 32'(bram_EN), 0);
      if (i < 4) tick;
    end
    @(posedge CLK); #1;
    x_ready = 1'b1;
  endtask

  task automatic feed(input logic [31:0] d, input bit stall);
    int cyc;
    bit stalled;
    int w;
    tap_t e;
    stalled = 1'b0;
    @(posedge CLK); #1;
    ss_tvalid = 1'b1;
    ss_tdata = d;
    cyc = 0;
    tick;
    while (!ss_tready && cyc < 50) begin tick; cyc++; end
    chk("ss_accept", 32'(ss_tready), 1);
    chk("wr_we", 32'(bram_WE), 32'hF);
    chk("wr_en", 32'(bram_EN), 1);
    chk("wr_addr", 32'(bram_A), 32'(m_ptr * 4));
    chk("wr_di", bram_Di, d);
    $display("sample %0h written at A=%0d", d, bram_A);
    ref_mem[m_ptr] = d;
    for (int k = 0; k < TAPS; k++) begin
      w = (m_ptr - k + TAPS) % TAPS;
      e.idx  = 4'(k);
      e.data = ref_mem[w];
      e.last = (k == TAPS - 1);
      e.fin  = (k == TAPS - 1) && (m_cnt == m_len - 1);
      sb.push_back(e);
    end
    m_ptr = (m_ptr + 1) % TAPS;
    m_cnt++;
    @(posedge CLK); #1;
    ss_tvalid = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 300) begin
      tick;
      cyc++;
      if (stall && !stalled && x_valid && x_ready && x_idx == 4'd2) begin
        stalled = 1'b1;
        stall_seq();
      end
    end
    chk("drain", 32'(sb.size()), 0);
  endtask

  task automatic run(input int len, input logic [31:0] base, input int stall_at, input bit do_cap);
    int d0;
    d0 = n_done;
    for (int i = 0; i < TAPS; i++) cap[i] = '{4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0};
    start(len);
    for (int i = 0; i < len; i++) begin
      cap_en = do_cap && (i == len - 1);
      feed(base + 32'(i), i == stall_at);
    end
    cap_en = 1'b0;
    tick;
    chk("ap_done_pulse", 32'(ap_done), 1);
    tick;
    chk("ap_done_clear", 32'(ap_done), 0);
    chk("ap_idle_after", 32'(ap_idle), 1);
    chk("done_count", 32'(n_done - d0), 1);
    $display("run len=%0d done", len);
  endtask

  task automatic cmp_table(input string tag);
    for (int i = 0; i < TAPS; i++) begin
      chk({tag, "_idx"}, 32'(cap[i].idx), 32'(vec[i].idx));
      chk({tag, "_data"}, cap[i].data, vec[i].data);
      chk({tag, "_last"}, 32'(cap[i].last), 32'(vec[i].last));
      chk({tag, "_final"}, 32'(cap[i].fin), 32'(vec[i].fin));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, found, w0, t0, d0;
    for (int i = 0; i < TAPS; i++) ref_mem[i] = '0;

    // Reset values
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    tick;
    chk("rst_idle", 32'(ap_idle), 1);
    chk("rst_done", 32'(ap_done), 0);
    chk("rst_tready", 32'(ss_tready), 0);
    chk("rst_xvalid", 32'(x_valid), 0);
    chk("rst_xdata", x_data, 0);
    chk("rst_xidx", 32'(x_idx), 0);
    chk("rst_xlast", 32'(x_last), 0);
    chk("rst_xfinal", 32'(x_final), 0);
    chk("rst_we", 32'(bram_WE), 0);
    chk("rst_en", 32'(bram_EN), 0);
    chk("rst_di", bram_Di, 0);
    chk("rst_a", 32'(bram_A), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Single sample 5 into a zeroed buffer
    for (int i = 0; i < TAPS; i++)
      vec[i] = '{4'(i), (i == 0) ? 32'd5 : 32'd0, i == TAPS - 1, i == TAPS - 1};
    run(1, 32'd5, -1, 1'b1);
    cmp_table("t_first");

    // Reset in the middle of OUT
    x_ready = 1'b0;
    start(5);
    @(posedge CLK); #1;
    ss_tvalid = 1'b1;
    ss_tdata = 32'h77;
    cyc = 0;
    tick;
    while (!ss_tready && cyc < 50) begin tick; cyc++; end
    chk("rst_run_accept", 32'(ss_tready), 1);
    ref_mem[m_ptr] = 32'h77;
    @(posedge CLK); #1;
    ss_tvalid = 1'b0;
    cyc = 0;
    tick;
    while (!x_valid && cyc < 20) begin tick; cyc++; end
    chk("rst_run_xvalid", 32'(x_valid), 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK);
    tick;
    chk("midrst_xvalid", 32'(x_valid), 0);
    chk("midrst_idle", 32'(ap_idle), 1);
    chk("midrst_tready", 32'(ss_tready), 0);
    chk("midrst_en", 32'(bram_EN), 0);
    $display("mid-run reset applied");
    @(posedge CLK); #1;
    RST = 1'b0;
    x_ready = 1'b1;
    m_ptr = 0;

    // Twelve samples: pointer wraps, last sample lands at word 0
    for (int i = 0; i < TAPS; i++)
      vec[i] = '{4'(i), 32'(12 - i), i == TAPS - 1, i == TAPS - 1};
    run(12, 32'd1, -1, 1'b1);
    cmp_table("t_wrap");

    // Back-pressure on tap 3 of the second sample
    run(3, 32'd100, 1, 1'b0);

    // Zero-length run
    w0 = n_wr; t0 = n_trdy; d0 = n_done;
    @(posedge CLK); #1;
    ap_start = 1'b1;
    data_length = 32'd0;
    @(posedge CLK); #1;
    ap_start = 1'b0;
    found = -1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (ap_done && found < 0) found = c;
    end
`ifdef FIR_DATA_CLEAR_EN
    chk("len0_done_cycle", 32'(found), 12);
    chk("len0_writes", 32'(n_wr - w0), 11);
`else
    chk("len0_done_cycle", 32'(found), 2);
    chk("len0_writes", 32'(n_wr - w0), 0);
`endif
    chk("len0_tready", 32'(n_trdy - t0), 0);
    chk("len0_done_count", 32'(n_done - d0), 1);
    chk("len0_idle", 32'(ap_idle), 1);
    $display("zero-length run done at cycle %0d", found);

    // Short run over stale contents
    run(2, 32'd200, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
